// File: rtl/alu_pkg.sv
// Shared encodings for the core ALU and the multi-cycle MUL/DIV sequencer:
// ALU control codes, M-extension op codes and the sequencer state enum.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL     = 3'd1,
        S_DIV_CMP = 3'd2,
        S_DIV_SUB = 3'd3,
        S_DONE    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational core ALU; the MUL/DIV sequencer borrows it through
// its control/operand port while the decoder holds the PC.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       control_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic [WIDTH-1:0] data_b_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        out_o = '0;
        case (control_i)
            ALU_ADD:  out_o = data_a_i + data_b_i;
            ALU_SUB:  out_o = data_a_i - data_b_i;
            ALU_AND:  out_o = data_a_i & data_b_i;
            ALU_OR:   out_o = data_a_i | data_b_i;
            ALU_XOR:  out_o = data_a_i ^ data_b_i;
            ALU_SLT:  out_o = {{(WIDTH-1){1'b0}}, $signed(data_a_i) < $signed(data_b_i)};
            ALU_SLTU: out_o = {{(WIDTH-1){1'b0}}, data_a_i < data_b_i};
            default:  out_o = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_shift_regs.sv
// Operand and partial-result registers for the sequencer: shift-add multiply
// (hi/lo/multiplier) and restoring divide (rem/quot/dividend).
module muldiv_shift_regs #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             mul_step,
    input  logic             div_step,
    input  logic             ge,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] mcand_q,
    output logic             mplier_lsb,
    output logic [WIDTH-1:0] divisor_q,
    output logic [WIDTH-1:0] rem_sh,
    output logic             ovf,
    output logic [WIDTH-1:0] hi_d,
    output logic [WIDTH-1:0] lo_d,
    output logic [WIDTH-1:0] rem_d,
    output logic [WIDTH-1:0] quot_d
);

    logic [WIDTH-1:0] lo_q, mplier_q, dvd_q, rem_q, quot_q;
    logic [WIDTH-1:0] sum;
    logic             carry;

    // The carry out of hi+mcand only exists when an add really happened;
    // on skipped steps the ALU result is meaningless.
    always_comb begin
        sum   = mplier_q[0] ? alu_out : hi_q;
        carry = mplier_q[0] & (alu_out < hi_q);
        hi_d  = {carry, sum[WIDTH-1:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        rem_d  = ge ? alu_out : rem_sh;
        quot_d = {quot_q[WIDTH-2:0], ge};
    end

    assign rem_sh     = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    assign ovf        = rem_q[WIDTH-1];
    assign mplier_lsb = mplier_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            dvd_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
        end else if (load) begin
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= src_a;
            mplier_q  <= src_b;
            dvd_q     <= src_a;
            divisor_q <= src_b;
            rem_q     <= '0;
            quot_q    <= '0;
        end else if (mul_step) begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mplier_q <= mplier_q >> 1;
        end else if (div_step) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvd_q  <= dvd_q << 1;
        end
    end

endmodule

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU controller that steps the shared
// core ALU once per cycle instead of owning its own adder.
module alu_muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_control,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CW = $clog2(WIDTH);

    seq_state_e       state_q, state_d;
    muldiv_op_e       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ge_q, ge_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             load, mul_step, div_step;

    logic [WIDTH-1:0] hi_q, mcand_q, divisor_q, rem_sh;
    logic [WIDTH-1:0] hi_d, lo_d, rem_d, quot_d;
    logic             mplier_lsb, ovf;

    muldiv_shift_regs #(.WIDTH(WIDTH)) u_regs (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .mul_step   (mul_step),
        .div_step   (div_step),
        .ge         (ge_q),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_out    (alu_out),
        .hi_q       (hi_q),
        .mcand_q    (mcand_q),
        .mplier_lsb (mplier_lsb),
        .divisor_q  (divisor_q),
        .rem_sh     (rem_sh),
        .ovf        (ovf),
        .hi_d       (hi_d),
        .lo_d       (lo_d),
        .rem_d      (rem_d),
        .quot_d     (quot_d)
    );

    // The result register is loaded on the edge that enters DONE, using the
    // final step's next-state values, so it is valid during the done pulse.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        ge_d        = ge_q;
        result_d    = result_q;
        load        = 1'b0;
        mul_step    = 1'b0;
        div_step    = 1'b0;
        alu_control = ALU_ADD;
        alu_a       = '0;
        alu_b       = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load  = 1'b1;
                    op_d  = muldiv_op_e'(op);
                    cnt_d = CW'(WIDTH - 1);
                    if (!op[1]) begin
                        state_d = S_MUL;
                    end else if (src_b != '0) begin
                        state_d = S_DIV_CMP;
                    end else begin
                        state_d  = S_DONE;
                        result_d = (op == OP_DIVU) ? '1 : src_a;
                    end
                end
            end
            S_MUL: begin
                mul_step = 1'b1;
                if (mplier_lsb) begin
                    alu_control = ALU_ADD;
                    alu_a       = hi_q;
                    alu_b       = mcand_q;
                end
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_MUL) ? lo_d : hi_d;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV_CMP: begin
                alu_control = ALU_SLTU;
                alu_a       = rem_sh;
                alu_b       = divisor_q;
                ge_d        = ovf | ~alu_out[0];
                state_d     = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                div_step = 1'b1;
                if (ge_q) begin
                    alu_control = ALU_SUB;
                    alu_a       = rem_sh;
                    alu_b       = divisor_q;
                end
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_DIVU) ? quot_d : rem_d;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    state_d = S_DIV_CMP;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            ge_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            ge_q     <= ge_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Self-checking bench: sequencer wired to the real ALU, table-driven ops
// with a result scoreboard, plus reset and ignored-start sequences.
module tb_alu_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_out;

    int tests = 0;
    int failed = 0;
    logic [31:0] expQ[$];
    int          latQ[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          expLat;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    alu #(.WIDTH(32)) u_alu (
        .control_i (alu_control),
        .data_a_i  (alu_a),
        .data_b_i  (alu_b),
        .out_o     (alu_out)
    );

    alu_muldiv_sequencer #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out)
    );

    function automatic logic [31:0] modelResult(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int modelLatency(logic [1:0] o, logic [31:0] b);
        if (!o[1]) return 33;
        return (b == 0) ? 1 : 65;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int cyc, input bit seen, input bit busyOk);
        logic [31:0] expRes;
        int          expLat;
        expRes = expQ.size() > 0 ? expQ.pop_front() : 32'hDEAD_BEEF;
        expLat = latQ.size() > 0 ? latQ.pop_front() : -1;
        check("done seen", 32'(seen), 32'd1);
        check("result", result, expRes);
        check("latency", 32'(cyc), 32'(expLat));
        check("busy span", 32'(busyOk), 32'd1);
        @(negedge clk);
        check("idle after done", {30'b0, busy, done}, 32'd0);
        check("result held", result, expRes);
        check("alu idle", {28'b0, alu_control} | alu_a | alu_b, 32'd0);
    endtask

    // Starts one op, optionally pulsing a competing start at cycle injectAt,
    // and waits (bounded) for done before scoring it.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat, input int injectAt);
        int cyc;
        bit seen;
        bit busyOk;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        expQ.push_back(expRes);
        latQ.push_back(expLat);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; seen = 1'b0; busyOk = 1'b1;
        while (cyc <= 200 && !seen) begin
            if (!busy) busyOk = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (cyc == injectAt) begin
                    start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        checkOutput(cyc, seen, busyOk);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        check("reset busy/done", {30'b0, busy, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset alu ctrl", {28'b0, alu_control}, 32'd0);
        check("reset alu ops", alu_a | alu_b, 32'd0);
        reset = 1'b0;

        vecs.push_back('{2'b00, 32'd7, 32'd6, 32'd42, 33});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
        vecs.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33});
        vecs.push_back('{2'b10, 32'd100, 32'd7, 32'd14, 65});
        vecs.push_back('{2'b11, 32'd100, 32'd7, 32'd2, 65});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'h8000_0001, 32'h0, 65});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 65});
        vecs.push_back('{2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{2'b11, 32'd5, 32'd0, 32'd5, 1});
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = (i == 5) ? ($urandom | 32'h8000_0000) : $urandom;
            vecs.push_back('{2'(i % 4), ra, rb, modelResult(2'(i % 4), ra, rb),
                             modelLatency(2'(i % 4), rb)});
        end

        foreach (vecs[i])
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expRes, vecs[i].expLat, 0);

        // Reset in the middle of a multiply discards the operation.
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-op busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid-op reset busy/done", {30'b0, busy, done}, 32'd0);
        check("mid-op reset result", result, 32'd0);
        reset = 1'b0;

        applyStimulus(2'b00, 32'd7, 32'd6, 32'd42, 33, 0);
        applyStimulus(2'b00, 32'd7, 32'd6, 32'd42, 33, 5);
        applyStimulus(2'b10, 32'd100, 32'd7, 32'd14, 65, 20);

        check("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
